top_linear_inverse_pipe: RTL

- Pipelined, valid/ready-handshaked top linear stage for the inverse AES S-box datapath (decrypt direction).
- Each accepted byte U (U[0] = byte MSB, the Boyar-Peralta bit convention) goes through the inverse affine map, giving W. W is then expanded into the same 27-signal T set and 8-bit pass-through that the shared nonlinear middle stage consumes.
- A per-beat dir bit bypasses the inverse affine so one instance serves both directions.
- Sits between the round-key XOR and the shared middle/bottom S-box stages.

---
 rtl/aes_sbox_pkg.sv | 20 ++
 rtl/top_linear_t_expand.sv | 45 ++++
 rtl/top_linear_inverse_pipe.sv | 69 ++++++
 3 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared constants and helpers for the AES S-box datapath.
// Bytes on the ports are MSB-first: vector bit 0 carries the AES byte MSB.
package aes_sbox_pkg;

  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam int         T_W          = 27;

  // Inverse affine map, taking and returning MSB-first bytes.
  function automatic logic [7:0] inv_affine(input logic [7:0] u);
    logic [7:0] b;
    logic [7:0] w;
    logic [7:0] r;
    for (int k = 0; k < 8; k++) b[7-k] = u[k];
    for (int i = 0; i < 8; i++)
      w[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8] ^ INV_AFFINE_C[i];
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return r;
  endfunction

endpackage

// File: rtl/top_linear_t_expand.sv
// Top linear expansion W -> T[0..26] feeding the shared nonlinear middle stage.
// Purely combinational; no handshake.
module top_linear_t_expand
  import aes_sbox_pkg::*;
(
  input  logic [7:0]     w,
  output logic [T_W-1:0] t
);

  logic [T_W-1:0] x;

  always_comb begin
    x     = '0;
    x[0]  = w[0] ^ w[3];
    x[1]  = w[0] ^ w[5];
    x[2]  = w[0] ^ w[6];
    x[3]  = w[3] ^ w[5];
    x[4]  = w[4] ^ w[6];
    x[5]  = x[0] ^ x[4];
    x[6]  = w[1] ^ w[2];
    x[7]  = w[7] ^ x[5];
    x[8]  = w[7] ^ x[6];
    x[9]  = x[5] ^ x[6];
    x[10] = w[1] ^ w[5];
    x[11] = w[2] ^ w[5];
    x[12] = x[2] ^ x[3];
    x[13] = x[5] ^ x[10];
    x[14] = x[4] ^ x[10];
    x[15] = x[4] ^ x[11];
    x[16] = x[8] ^ x[15];
    x[17] = w[3] ^ w[7];
    x[18] = x[6] ^ x[17];
    x[19] = x[0] ^ x[18];
    x[20] = w[6] ^ w[7];
    x[21] = x[6] ^ x[20];
    x[22] = x[1] ^ x[21];
    x[23] = x[1] ^ x[9];
    x[24] = x[19] ^ x[16];
    x[25] = x[2] ^ x[15];
    x[26] = x[0] ^ x[11];
  end

  assign t = x;

endmodule

// File: rtl/top_linear_inverse_pipe.sv
// Inverse-affine + top linear stage of the shared S-box, 2-cycle latency, 1 beat/cycle.
// Backpressure: in_ready follows out_ready combinationally; empty stages fill while stalled.
module top_linear_inverse_pipe
  import aes_sbox_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_u,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [T_W-1:0]   out_t,
  output logic [7:0]       out_w,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_vld, s2_vld;
  logic [7:0]       s1_w, s2_w;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [T_W-1:0]   s2_t, t_nxt;
  logic             s1_adv, s2_adv;
  logic [7:0]       w_nxt;

  assign s2_adv   = !s2_vld || out_ready;
  assign s1_adv   = !s1_vld || s2_adv;
  assign in_ready = s1_adv;

  // Forward-direction beats skip the inverse affine so one instance serves both ways.
  assign w_nxt = in_dir ? in_u : inv_affine(in_u);

  top_linear_t_expand u_t_expand (
    .w (s1_w),
    .t (t_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (s1_adv) s1_vld <= in_valid;
      if (s2_adv) s2_vld <= s1_vld;
    end
  end

  // Payload registers carry no reset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_w   <= w_nxt;
      s1_tag <= in_tag;
    end
    if (s2_adv && s1_vld) begin
      s2_t   <= t_nxt;
      s2_w   <= s1_w;
      s2_tag <= s1_tag;
    end
  end

  assign out_valid = s2_vld;
  assign out_t     = s2_vld ? s2_t   : '0;
  assign out_w     = s2_vld ? s2_w   : '0;
  assign out_tag   = s2_vld ? s2_tag : '0;

endmodule
